stamp_to_hms: RTL and testbench

//   Converts a seconds-of-day stamp into binary hour/min/sec fields.
//   It is the downstream inverse of time2stamp, used by display, alarm and readback paths.
//   A multi-cycle restoring divider keeps area small: first stamp/3600, then remainder/60.
//   A start/busy/done handshake couples it to the stamp producer.

---
 rtl/clock_pkg.sv | 24 ++
 rtl/serial_div.sv | 70 +++++++
 rtl/stamp_to_hms.sv | 159 +++++++++++++++
 tb/tb_stamp_to_hms.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared time-of-day constants and FSM encoding for the stamp/HMS converters.
// Pure declarations, no logic.
// Imported by stamp_to_hms, serial_div and neighbouring clock blocks.
package clock_pkg;

    localparam int SEC_PER_HOUR  = 3600;
    localparam int SEC_PER_MIN   = 60;
    localparam int DAY_SECONDS   = 86400;

    // Divider geometry: a valid stamp fits in 17 bits, a sub-hour remainder in 12.
    localparam int DIV_W         = 17;
    localparam int DVS_W         = 12;
    localparam int CNT_W         = 5;
    localparam int HOUR_DIV_BITS = 17;
    localparam int MIN_DIV_BITS  = 12;
    localparam int HOUR_W        = 5;

    // Converter FSM encoding, kept here so sibling blocks decode it identically.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DIV_H = 2'd1;
    localparam logic [1:0] S_DIV_M = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/serial_div.sv
// Restoring divider, one quotient bit per cycle, MSB first.
// Latency: nbits steps after load; quot/rem show the post-step value, final when last=1.
// No backpressure: a load restarts the divider immediately, overriding any step in flight.
module serial_div #(
    parameter int DW = 17,
    parameter int VW = 12,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    input  logic [CW-1:0] nbits,
    output logic [DW-1:0] quot,
    output logic [VW-1:0] rem,
    output logic          last
);

    logic [DW-1:0] dvd_q;
    logic [DW-2:0] quot_q;
    logic [VW-1:0] rem_q;
    logic [VW-1:0] dvs_q;
    logic [CW-1:0] cnt_q;
    logic          act_q;

    logic [VW:0]   trial;
    logic          ge;
    logic [CW-1:0] align;

    // One restoring step: shift in the next dividend bit and subtract when it fits.
    always_comb begin
        trial = {rem_q, dvd_q[DW-1]};
        ge    = (trial >= {1'b0, dvs_q});
        rem   = ge ? VW'(trial - {1'b0, dvs_q}) : trial[VW-1:0];
        quot  = {quot_q, ge};
        last  = act_q && (cnt_q == '0);
        // Narrow dividends are left-aligned so the first step sees their MSB.
        align = CW'(DW) - nbits;
    end

    // Divider state: load captures operands, otherwise step until the count expires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            act_q  <= 1'b0;
        end else if (load) begin
            dvd_q  <= dividend << align;
            quot_q <= '0;
            rem_q  <= '0;
            dvs_q  <= divisor;
            cnt_q  <= nbits - CW'(1);
            act_q  <= 1'b1;
        end else if (act_q) begin
            dvd_q  <= {dvd_q[DW-2:0], 1'b0};
            quot_q <= quot[DW-2:0];
            rem_q  <= rem;
            if (cnt_q == '0) begin
                act_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/stamp_to_hms.sv
// Seconds-of-day stamp to binary hour/min/sec via a shared serial divider.
// Latency: 30 cycles from accepting edge for a valid stamp, 1 cycle for an out-of-range stamp.
// No queueing: start is only sampled in IDLE; requests while busy (including DONE) are dropped.
module stamp_to_hms #(
    parameter int STAMP_W     = 32,
    parameter int OUT_W       = 8,
    parameter int DAY_SECONDS = 86400
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [STAMP_W-1:0] stamp,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [OUT_W-1:0]   hour,
    output logic [OUT_W-1:0]   min,
    output logic [OUT_W-1:0]   sec
);

    import clock_pkg::SEC_PER_HOUR;
    import clock_pkg::SEC_PER_MIN;
    import clock_pkg::DIV_W;
    import clock_pkg::DVS_W;
    import clock_pkg::CNT_W;
    import clock_pkg::HOUR_DIV_BITS;
    import clock_pkg::MIN_DIV_BITS;
    import clock_pkg::HOUR_W;
    import clock_pkg::S_IDLE;
    import clock_pkg::S_DIV_H;
    import clock_pkg::S_DIV_M;
    import clock_pkg::S_DONE;

    logic [1:0]        state_q,  state_d;
    logic [HOUR_W-1:0] hpart_q,  hpart_d;
    logic [OUT_W-1:0]  hour_q,   hour_d;
    logic [OUT_W-1:0]  min_q,    min_d;
    logic [OUT_W-1:0]  sec_q,    sec_d;
    logic              err_q,    err_d;

    logic              accept;
    logic              stamp_bad;
    logic              div_load;
    logic [DIV_W-1:0]  div_dividend;
    logic [DVS_W-1:0]  div_divisor;
    logic [CNT_W-1:0]  div_nbits;
    logic [DIV_W-1:0]  div_quot;
    logic [DVS_W-1:0]  div_rem;
    logic              div_last;
    logic              unused_quot_hi;

    // Request acceptance and divider operand selection for the hour and minute phases.
    always_comb begin
        accept    = (state_q == S_IDLE) && start;
        // Any stamp with bits above [16] set is already past the day, so one compare covers both.
        stamp_bad = (stamp >= STAMP_W'(DAY_SECONDS));
        // The minute phase is loaded on the same edge the hour phase finishes, straight
        // from the divider's post-step remainder, so no cycle is lost between phases.
        div_load  = (accept && !stamp_bad) || ((state_q == S_DIV_H) && div_last);
        if (state_q == S_IDLE) begin
            div_dividend = stamp[DIV_W-1:0];
            div_divisor  = DVS_W'(SEC_PER_HOUR);
            div_nbits    = CNT_W'(HOUR_DIV_BITS);
        end else begin
            div_dividend = DIV_W'(div_rem);
            div_divisor  = DVS_W'(SEC_PER_MIN);
            div_nbits    = CNT_W'(MIN_DIV_BITS);
        end
    end

    serial_div #(
        .DW(DIV_W),
        .VW(DVS_W),
        .CW(CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .nbits    (div_nbits),
        .quot     (div_quot),
        .rem      (div_rem),
        .last     (div_last)
    );

    // Hour quotient never exceeds 23 and minute quotient never exceeds 59.
    assign unused_quot_hi = ^div_quot[DIV_W-1:6];

    // FSM next state; results and err are committed together on entry to DONE.
    always_comb begin
        state_d = state_q;
        hpart_d = hpart_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (stamp_bad) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        hour_d  = '0;
                        min_d   = '0;
                        sec_d   = '0;
                    end else begin
                        state_d = S_DIV_H;
                    end
                end
            end
            S_DIV_H: begin
                if (div_last) begin
                    hpart_d = div_quot[HOUR_W-1:0];
                    state_d = S_DIV_M;
                end
            end
            S_DIV_M: begin
                if (div_last) begin
                    hour_d  = OUT_W'(hpart_q);
                    min_d   = OUT_W'(div_quot[5:0]);
                    sec_d   = OUT_W'(div_rem[5:0]);
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion and clears the results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hpart_q <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hpart_q <= hpart_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign err  = err_q;
    assign hour = hour_q;
    assign min  = min_q;
    assign sec  = sec_q;

endmodule

// File: tb/tb_stamp_to_hms.sv
// Self-checking bench for stamp_to_hms: directed cases plus randomized traffic.
// A countdown model predicts busy/done and the held results every cycle.
// Results come from plain division of the stamp, independent of the RTL divider.
module tb_stamp_to_hms;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] stamp = 32'd0;
    logic        busy, done, err;
    logic [7:0]  hour, min, sec;

    stamp_to_hms #(
        .STAMP_W     (32),
        .OUT_W       (8),
        .DAY_SECONDS (86400)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stamp (stamp),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .hour  (hour),
        .min   (min),
        .sec   (sec)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference conversion, packed as {err, hour, min, sec}.
    function automatic logic [24:0] ref_hms(input logic [31:0] s);
        int unsigned v;
        v = s;
        if (v >= 86400) return {1'b1, 24'd0};
        return {1'b0, 8'(v / 3600), 8'((v % 3600) / 60), 8'(v % 60)};
    endfunction

    function automatic logic [31:0] pick_stamp();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: return 32'($urandom_range(0, 86399));
            5:             return 32'd86399;
            6:             return 32'd86400;
            7:             return 32'd0;
            8:             return $urandom;
            default:       return 32'($urandom_range(86400, 131071));
        endcase
    endfunction

    // Model: m_left counts the busy cycles still to come (0 = idle, 1 = done cycle).
    int          m_left   = 0;
    logic [24:0] m_pend   = 25'd0;
    logic [24:0] m_out    = 25'd0;
    int          done_cnt = 0;
    int          cyc      = 0;

    always @(posedge clk) begin
        cyc++;
        if (done === 1'b1) done_cnt++;
        if (!rst_n) begin
            m_left = 0;
            m_out  = 25'd0;
        end else if (m_left == 0) begin
            if (start) begin
                m_pend = ref_hms(stamp);
                m_left = m_pend[24] ? 1 : 30;
                if (m_left == 1) m_out = m_pend;
            end
        end else begin
            m_left--;
            if (m_left == 1) m_out = m_pend;
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", busy, (m_left > 0));
        chk("cyc_done", done, (m_left == 1));
        chk("cyc_err",  err,  m_out[24]);
        chk("cyc_hour", hour, m_out[23:16]);
        chk("cyc_min",  min,  m_out[15:8]);
        chk("cyc_sec",  sec,  m_out[7:0]);
    end

    // One start pulse, then wait (bounded) for done; checks latency, busy span and results.
    task automatic run_one(input string tag, input logic [31:0] s, input int exp_lat,
                           input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                           input logic ee);
        int n;
        int nb;
        @(negedge clk);
        start = 1'b1;
        stamp = s;
        @(negedge clk);
        start = 1'b0;
        stamp = $urandom;
        n  = 1;
        nb = busy ? 1 : 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_busy_cycles"}, nb, exp_lat);
        chk({tag, "_err"},  err,  ee);
        chk({tag, "_hour"}, hour, eh);
        chk({tag, "_min"},  min,  em);
        chk({tag, "_sec"},  sec,  es);
        @(negedge clk);
        chk({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        int d0;
        int n;
        int nd;
        int t_done [3];

        // Model pinned against hand-computed values.
        chk("model_45045", ref_hms(32'd45045), {1'b0, 8'd12, 8'd30, 8'd45});
        chk("model_86399", ref_hms(32'd86399), {1'b0, 8'd23, 8'd59, 8'd59});
        chk("model_86400", ref_hms(32'd86400), {1'b1, 24'd0});

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err",  err,  1'b0);
        chk("rst_hms",  {hour, min, sec}, 24'd0);
        rst_n = 1'b1;

        run_one("t1_45045", 32'd45045, 30, 8'd12, 8'd30, 8'd45, 1'b0);
        run_one("t2_zero",  32'd0,     30, 8'd0,  8'd0,  8'd0,  1'b0);
        run_one("t2_max",   32'd86399, 30, 8'd23, 8'd59, 8'd59, 1'b0);
        run_one("t3_day",   32'd86400, 1,  8'd0,  8'd0,  8'd0,  1'b1);
        run_one("t3_ones",  32'hFFFF_FFFF, 1, 8'd0, 8'd0, 8'd0, 1'b1);
        run_one("t3_bit17", 32'h0002_0000, 1, 8'd0, 8'd0, 8'd0, 1'b1);

        // Starts at +5 and during DONE must be dropped.
        @(negedge clk);
        start = 1'b1;
        stamp = 32'd3661;
        @(negedge clk);
        start = 1'b0;
        d0    = done_cnt;
        repeat (4) @(negedge clk);
        start = 1'b1;
        stamp = 32'd7200;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        chk("t4_hms", {err, hour, min, sec}, {1'b0, 8'd1, 8'd1, 8'd1});
        @(negedge clk);
        start = 1'b0;
        chk("t4_idle_after_done", busy, 1'b0);
        repeat (35) @(negedge clk);
        chk("t4_done_pulses", done_cnt - d0, 1);
        chk("t4_hms_held", {err, hour, min, sec}, {1'b0, 8'd1, 8'd1, 8'd1});

        // Reset mid-conversion aborts with no done pulse and zeroed outputs.
        @(negedge clk);
        start = 1'b1;
        stamp = 32'd45045;
        @(negedge clk);
        start = 1'b0;
        stamp = 32'd0;
        d0    = done_cnt;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_hms",  {err, hour, min, sec}, 25'd0);
        repeat (40) @(negedge clk);
        chk("t5_no_done", done_cnt - d0, 0);
        run_one("t5_fresh", 32'd59, 30, 8'd0, 8'd0, 8'd59, 1'b0);

        // Start held high: re-accepted each idle cycle. Period is one IDLE cycle,
        // 29 divider cycles and the DONE cycle.
        for (int i = 0; i < 3; i++) t_done[i] = 0;
        nd = 0;
        n  = 0;
        @(negedge clk);
        start = 1'b1;
        stamp = 32'd3599;
        while (nd < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                t_done[nd] = cyc;
                chk("t6_hms", {err, hour, min, sec}, {1'b0, 8'd0, 8'd59, 8'd59});
                nd++;
            end
        end
        start = 1'b0;
        chk("t6_done_count", nd, 3);
        chk("t6_spacing_a", t_done[1] - t_done[0], 31);
        chk("t6_spacing_b", t_done[2] - t_done[1], 31);
        repeat (40) @(negedge clk);

        // Randomized traffic: starts, stamp churn and occasional resets.
        d0 = done_cnt;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            stamp = pick_stamp();
            rst_n = ($urandom_range(0, 399) != 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rand_done_seen", (done_cnt - d0) > 20, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
